// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared types and helpers for the sequential shift-add multiplier
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

  // Controller states, 2-bit explicit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

  // Bits needed for a counter that has to reach the value w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/cond_negate.sv
`default_nettype none
// ============================================================================
//  Module   : cond_negate
//  Purpose  : Combinational conditional two's-complement negation
//  Revision : 1.0  initial release
// ============================================================================
module cond_negate #(
  parameter int WIDTH = 4
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Invert-and-increment when negation is requested, otherwise pass through
  always_comb begin
    out = neg ? (~in + ONE) : in;
  end

endmodule : cond_negate
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Radix-2 shift-add multiplier, signed/unsigned, start/done
//             handshake. One WIDTH+1 bit adder reused over WIDTH cycles.
//  Revision : 1.0  initial release
// ============================================================================
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mult_state_t          state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic                 neg_q,    neg_d;
  logic [2*WIDTH-1:0]   p_q,      p_d;

  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   p_fixed;
  logic [WIDTH:0]       add_sum;

  // Operand signs only matter in signed mode; the unsigned magnitude of the
  // most negative value is still representable, so no special case exists.
  always_comb begin
    a_neg = signed_mode & a[WIDTH-1];
    b_neg = signed_mode & b[WIDTH-1];
  end

  cond_negate #(.WIDTH(WIDTH)) u_abs_a (
    .neg (a_neg),
    .in  (a),
    .out (a_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_abs_b (
    .neg (b_neg),
    .in  (b),
    .out (b_mag)
  );

  cond_negate #(.WIDTH(2*WIDTH)) u_fix_p (
    .neg (neg_q),
    .in  (acc_q),
    .out (p_fixed)
  );

  // Partial-product add into the upper accumulator half, carry kept in bit WIDTH
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  end

  // Next-state and datapath update; every register holds unless changed
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        // {carry, acc} shifted right by one: the carry lands in the MSB
        acc_d    = {add_sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        p_d     = p_fixed;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state_q == ST_CALC) || (state_q == ST_FIX);
    done = (state_q == ST_DONE);
    p    = p_q;
  end

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_multiplier
//  Purpose  : Scoreboard bench for seq_multiplier (WIDTH=4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .p           (p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference product using native multiplication operators
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic sm);
    logic signed [2*W-1:0] s;
    logic [2*W-1:0]        u;
    s = $signed(x) * $signed(y);
    u = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return sm ? s : u;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got p=%0h expected no done (cycle %0d)", p, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", 32'(p), 32'(e.p));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one request at the current negedge, register its expectation
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sm, input logic [2*W-1:0] exp_p);
    exp_t e;
    a = x; b = y; signed_mode = sm; start = 1'b1;
    e.p   = exp_p;
    e.cyc = cyc + W + 2;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for the done cycle so the next start lands in DONE
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3*W) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=0 expected done=1 (cycle %0d)", cyc);
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_p",    32'(p),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 15*15: busy for exactly W+1 cycles, then done, p held
    issue(4'hF, 4'hF, 1'b0, 8'hE1);
    for (int i = 0; i < W + 1; i++) begin
      check("busy_window", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("busy_in_done", 32'(busy), 32'd0);
    check("done_pulse",   32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check("done_low_after", 32'(done), 32'd0);
    check("p_held", 32'(p), 32'hE1);

    // Signed corner cases
    issue(4'h8, 4'h8, 1'b1, 8'h40);
    wait_done();
    issue(4'hD, 4'h5, 1'b1, 8'hF1);
    wait_done();
    issue(4'h7, 4'hF, 1'b1, 8'hF9);
    wait_done();
    @(negedge clk);

    // Start during CALC is ignored; start in DONE restarts with no gap
    issue(4'h3, 4'h2, 1'b0, 8'h06);
    @(negedge clk);
    a = 4'h9; b = 4'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(4'h9, 4'h9, 1'b0, 8'h51);
    wait_done();
    @(negedge clk);

    // Asynchronous reset during CALC aborts the operation
    issue(4'hF, 4'hF, 1'b0, 8'hE1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p",    32'(p),    32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(4'h2, 4'h3, 1'b0, 8'h06);
    wait_done();
    @(negedge clk);
    check("p_after_reset", 32'(p), 32'h06);

    // All operand pairs in both modes, back-to-back through the DONE cycle
    for (int sm = 0; sm < 2; sm++) begin
      for (int x = 0; x < (1 << W); x++) begin
        for (int y = 0; y < (1 << W); y++) begin
          if (!(sm == 0 && x == 0 && y == 0)) wait_done();
          issue(W'(x), W'(y), 1'(sm), ref_mul(W'(x), W'(y), 1'(sm)));
        end
      end
    end

    // Drain outstanding results
    for (int i = 0; i < 4*W && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_multiplier
`default_nettype wire

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential radix-2 shift-add multiplier; multi-cycle successor to the combinational 4x4 array multiplier.
- Parametrised operand width; run-time signed/unsigned mode; start/done handshake.
- Sits between the operand registers (switch/keypad capture) and the display/accumulator logic in the lab datapath.
- Trades area for latency: one adder of WIDTH+1 bits instead of an adder array.

Parameters:
- WIDTH, 4, operand width in bits (valid range 2..16); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; p valid this cycle
- p  output  2*WIDTH  product; held until the next result is loaded

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0; done=0; p=0.
  - All internal registers (accumulator, multiplicand, shift register, counter, sign flag) cleared.
  - Reset mid-operation aborts the operation; no partial result reaches p.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Capture signed_mode.
  - Multiplicand register <= |a|; multiplier shift register <= |b|. When signed_mode=0, magnitude = raw value.
  - neg_flag <= signed_mode & (a[MSB] ^ b[MSB]).
  - Clear accumulator; counter <= 0; go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC, one bit per clock:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator. The carry is kept in one extra bit.
  - Shift {carry, accumulator} right by 1; shift the multiplier right by 1; counter++.
  - After WIDTH cycles, go to FIX.
- FIX:
  - p <= neg_flag ? two's-complement negation of the accumulator : accumulator.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - start=1: accepted exactly as in IDLE and goes to CALC (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge 0 -> done=1 in the cycle after edge WIDTH+1 (WIDTH+2 clocks start-to-done, including the DONE cycle). Throughput is one result per WIDTH+2 clocks.
- start while busy=1 is ignored with no side effects. Operand and mode changes during CALC/FIX have no effect.
- Signed magnitude: the most negative operand (-2^(WIDTH-1)) has magnitude 2^(WIDTH-1), which is representable in WIDTH unsigned bits, so no special case is needed.
  - The maximum signed product (-2^(W-1))^2 = 2^(2W-2) fits in 2W signed bits.
- Unsigned maximum: (2^W-1)^2 fits in 2W bits; the carry bit never propagates out of the final accumulator.
- p changes only on the FIX->DONE edge or on reset. Otherwise it is stable for downstream sampling.
- Counter width: clog2(WIDTH+1).

Decomposition:
- Package mult_pkg:
  - state encoding (IDLE, CALC, FIX, DONE) as a 2-bit localparam set;
  - a function or localparam for the counter width.
- Sub-module cond_negate (WIDTH-parametrised, combinational): out = neg ? -in : in.
  - Instantiated for |a|, for |b|, and for the final product sign fix (at 2*WIDTH).

Test Plan:
- Unsigned, WIDTH=4: a=15, b=15, start for one cycle -> busy for 5 cycles, done pulse on clock 6, p=8'hE1 (225); p held at 8'hE1 afterwards.
- Signed, WIDTH=4: a=4'b1000 (-8), b=4'b1000 -> p=8'h40 (+64). Also a=-3 (4'hD), b=5 -> p=8'hF1 (-15); a=7, b=-1 -> p=8'hF9.
- Handshake: pulse start with 3*2 and, during CALC, raise start with 9*9 -> second request ignored, p=8'h06. Then start in the DONE cycle with 9*9 -> no IDLE gap; next done gives p=8'h51.
- Reset mid-operation: assert rst at CALC cycle 2 of 15*15 -> busy=0, done=0, p=0 immediately (asynchronous). After release, 2*3 -> p=8'h06 with normal latency.
- Exhaustive, WIDTH=4 and WIDTH=8: all operand pairs in both modes compared against a reference model. done must occur exactly WIDTH+2 clocks after start, with no done for ignored starts.
